seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 21 ++
 rtl/seq_divider.sv | 102 ++++++++++
 tb/tb_seq_divider.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the 8/4 sequential divider.
interface seq_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring 8-bit / 4-bit unsigned divider: one quotient bit per cycle, MSB first,
// results registered on entry to DONE and held until the next accepted start.
module seq_divider (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [4:0] prem;
  logic [7:0] qacc;
  logic [2:0] cnt;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div_by_zero;

  logic       dvd_bit;
  logic [5:0] wide;
  logic [4:0] diff;
  logic       qbit;
  logic [4:0] prem_nxt;

  // Operands stay frozen while busy; the current bit is selected by the counter.
  always_comb begin
    dvd_bit  = dvd[3'd7 - cnt];
    wide     = {prem, dvd_bit};
    qbit     = (wide >= {2'b00, dvs});
    diff     = wide[4:0] - {1'b0, dvs};
    prem_nxt = qbit ? diff : wide[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= 8'h00;
      dvs         <= 4'h0;
      prem        <= 5'h00;
      qacc        <= 8'h00;
      cnt         <= 3'd0;
      quotient    <= 8'h00;
      remainder   <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            dvd  <= bus.dividend;
            dvs  <= bus.divisor;
            prem <= 5'h00;
            qacc <= 8'h00;
            cnt  <= 3'd0;
            if (bus.divisor == 4'h0) begin
              // Zero divisor skips CALC entirely and reports a saturated quotient.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= 8'hFF;
              remainder   <= bus.dividend[3:0];
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          qacc <= {qacc[6:0], qbit};
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quotient  <= {qacc[6:0], qbit};
            remainder <= prem_nxt[3:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus a shuffled sweep of every operand pair,
// checked against plain integer division.
module tb_seq_divider;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_divider_if dif ();

  seq_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_q(input logic [7:0] a, input logic [3:0] b);
    return (b == 4'h0) ? 8'hFF : 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [3:0] exp_r(input logic [7:0] a, input logic [3:0] b);
    return (b == 4'h0) ? a[3:0] : 4'(int'(a) % int'(b));
  endfunction

  // Issue one operation from IDLE and follow it to its done pulse (bounded).
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        output int busy_cnt, output int lat,
                        output bit overlap, output bit qchg);
    logic [7:0] q0;
    logic [3:0] r0;
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    busy_cnt = 0; lat = 0; overlap = 1'b0; qchg = 1'b0;
    q0 = dif.quotient; r0 = dif.remainder;
    for (int i = 1; i <= 20; i++) begin
      if (dif.busy && dif.done) overlap = 1'b1;
      if (dif.busy) begin
        busy_cnt++;
        if (dif.quotient !== q0 || dif.remainder !== r0) qchg = 1'b1;
      end
      if (dif.done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.start = 1'b0; dif.dividend = 8'h00; dif.divisor = 4'h0;
    #2;
    checks++;
    if ({dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero} !== 15'h0) begin
      errors++;
      $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
               dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic test_basic();
    int bc, lat; bit ov, qc;
    do_div(8'h6E, 4'hA, bc, lat, ov, qc);
    checks++;
    if (bc != 8 || lat != 9) begin
      errors++;
      $display("FAIL basic_timing: got busy_cycles=%0d done_at=%0d, want 8 9", bc, lat);
    end
    checks++;
    if (dif.quotient !== 8'h0B || dif.remainder !== 4'h0 || dif.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%h r=%h dbz=%b, want 0b 0 0",
               dif.quotient, dif.remainder, dif.div_by_zero);
    end
    checks++;
    if (ov || qc || dif.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got overlap=%b qchange=%b done_after=%b, want 0 0 0",
               ov, qc, dif.done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_t [4] = '{8'h96, 8'h7E, 8'hA5, 8'hC8};
    logic [3:0] b_t [4] = '{4'hA, 4'hE, 4'hF, 4'h7};
    logic [7:0] q_t [4] = '{8'h0F, 8'h09, 8'h0B, 8'h1C};
    logic [3:0] r_t [4] = '{4'h0, 4'h0, 4'h0, 4'h4};
    int bc, lat; bit ov, qc;
    for (int k = 0; k < 4; k++) begin
      do_div(a_t[k], b_t[k], bc, lat, ov, qc);
      checks++;
      if (dif.quotient !== q_t[k] || dif.remainder !== r_t[k] || lat != 9 || qc) begin
        errors++;
        $display("FAIL b2b_%0d: got q=%h r=%h done_at=%0d qchange=%b, want q=%h r=%h 9 0",
                 k, dif.quotient, dif.remainder, lat, qc, q_t[k], r_t[k]);
      end
    end
    // Results must hold across idle cycles with operands wiggling.
    for (int i = 0; i < 5; i++) begin
      dif.dividend = 8'($urandom); dif.divisor = 4'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (dif.quotient !== 8'h1C || dif.remainder !== 4'h4) begin
      errors++;
      $display("FAIL hold_idle: got q=%h r=%h, want 1c 4", dif.quotient, dif.remainder);
    end
  endtask

  task automatic test_div_zero();
    int bc, lat; bit ov, qc;
    do_div(8'h3C, 4'h0, bc, lat, ov, qc);
    checks++;
    if (lat != 1 || bc != 0) begin
      errors++;
      $display("FAIL dz_timing: got done_at=%0d busy_cycles=%0d, want 1 0", lat, bc);
    end
    checks++;
    if (dif.quotient !== 8'hFF || dif.remainder !== 4'hC || dif.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: got q=%h r=%h dbz=%b, want ff c 1",
               dif.quotient, dif.remainder, dif.div_by_zero);
    end
    do_div(8'h05, 4'h9, bc, lat, ov, qc);
    checks++;
    if (dif.div_by_zero !== 1'b0 || dif.quotient !== 8'h00 || dif.remainder !== 4'h5) begin
      errors++;
      $display("FAIL small_after_dz: got q=%h r=%h dbz=%b, want 00 5 0",
               dif.quotient, dif.remainder, dif.div_by_zero);
    end
  endtask

  task automatic test_start_ignored();
    int bc, lat;
    dif.dividend = 8'hFF; dif.divisor = 4'h1; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    bc = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) begin
        dif.start = 1'b1; dif.dividend = 8'h10; dif.divisor = 4'h3;
      end else if (i == 5) begin
        dif.start = 1'b0;
      end
      if (dif.busy) bc++;
      if (dif.done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat != 9 || bc != 8 || dif.quotient !== 8'hFF || dif.remainder !== 4'h0) begin
      errors++;
      $display("FAIL start_ignored: got q=%h r=%h done_at=%0d busy_cycles=%0d, want ff 0 9 8",
               dif.quotient, dif.remainder, lat, bc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int seen, bc, lat; bit ov, qc;
    dif.dividend = 8'h64; dif.divisor = 4'h9; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero} !== 15'h0) begin
      errors++;
      $display("FAIL abort_clear: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
               dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dif.done || dif.busy) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
    end
    do_div(8'h64, 4'h9, bc, lat, ov, qc);
    checks++;
    if (dif.quotient !== 8'h0B || dif.remainder !== 4'h1 || lat != 9) begin
      errors++;
      $display("FAIL after_abort: got q=%h r=%h done_at=%0d, want 0b 1 9",
               dif.quotient, dif.remainder, lat);
    end
  endtask

  task automatic test_sweep();
    int order [4096];
    int j, tmp, bc, lat, shown;
    bit ov, qc;
    logic [11:0] p;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    shown = 0;
    for (int k = 0; k < 4096; k++) begin
      p = order[k][11:0];
      a = p[11:4];
      b = p[3:0];
      do_div(a, b, bc, lat, ov, qc);
      checks++;
      if (dif.quotient !== exp_q(a, b) || dif.remainder !== exp_r(a, b) ||
          dif.div_by_zero !== (b == 4'h0) || lat != ((b == 4'h0) ? 1 : 9) || ov) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL sweep %h/%h: got q=%h r=%h dbz=%b done_at=%0d overlap=%b, want q=%h r=%h dbz=%b",
                   a, b, dif.quotient, dif.remainder, dif.div_by_zero, lat, ov,
                   exp_q(a, b), exp_r(a, b), (b == 4'h0));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
